// File: rtl/audio_nios_onchip_mem_arbiter_pkg.sv
// Shared types and default parameters for the two-master on-chip memory arbiter.
package audio_nios_onchip_mem_arbiter_pkg;

  localparam int DEF_ADDR_W    = 17;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_DEPTH     = 80000;
  localparam int DEF_MAX_BURST = 4;

  // Arbiter ownership state: nobody, master 0 or master 1 holds the grant.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_t;

  // Master identifier used for round-robin history and read-return steering.
  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_t;

endpackage

// File: rtl/audio_nios_rr_pick2.sv
// Two-way round-robin picker: on contention the master not served last wins.
module audio_nios_rr_pick2
  import audio_nios_onchip_mem_arbiter_pkg::*;
(
  input  logic    i_req0,
  input  logic    i_req1,
  input  master_t i_last,
  output logic    o_valid,
  output master_t o_pick
);

  // Choose a winner from the current requests and the last-served history.
  always_comb begin
    o_valid = i_req0 | i_req1;
    o_pick  = M0;
    if (i_req0 && i_req1) begin
      o_pick = (i_last == M1) ? M0 : M1;
    end else if (i_req1) begin
      o_pick = M1;
    end else begin
      o_pick = M0;
    end
  end

endmodule

// File: rtl/audio_nios_onchip_mem_arbiter.sv
// Two-master arbiter in front of a single-port on-chip RAM with bounded
// bursts, round-robin on contention and out-of-range access trapping.
module audio_nios_onchip_mem_arbiter
  import audio_nios_onchip_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                mem_clken,
  output logic                oob_err
);

  localparam int                CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0]  MAX_CNT = CNT_W'(MAX_BURST);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0]    w_cnt_inc;
  master_t             r_last;
  logic                r_rd_pend;
  master_t             r_rd_id;
  logic                r_rd_oob;
  logic                r_oob_err;

  logic                w_req0;
  logic                w_req1;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_acc;
  logic                w_cont;
  logic                w_rr_valid;
  master_t             w_rr_pick;
  logic [ADDR_W-1:0]   w_addr;
  logic                w_wr;
  logic                w_in_range;
  logic [DATA_W-1:0]   w_rdata;

  assign w_req0 = m0_read | m0_write;
  assign w_req1 = m1_read | m1_write;

  audio_nios_rr_pick2 u_rr_pick (
    .i_req0  (w_req0),
    .i_req1  (w_req1),
    .i_last  (r_last),
    .o_valid (w_rr_valid),
    .o_pick  (w_rr_pick)
  );

  // Combinational grant: the owner keeps priority, otherwise hand over in the same cycle.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (reset) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_rr_valid) begin
            w_gnt0 = (w_rr_pick == M0);
            w_gnt1 = (w_rr_pick == M1);
          end else begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
          end
        end
        ST_OWN0: begin
          if (w_req0) begin
            w_gnt0 = 1'b1;
          end else if (w_req1) begin
            w_gnt1 = 1'b1;
          end else begin
            w_gnt0 = 1'b0;
          end
        end
        ST_OWN1: begin
          if (w_req1) begin
            w_gnt1 = 1'b1;
          end else if (w_req0) begin
            w_gnt0 = 1'b1;
          end else begin
            w_gnt1 = 1'b0;
          end
        end
        default: begin
          w_gnt0 = 1'b0;
          w_gnt1 = 1'b0;
        end
      endcase
    end
  end

  assign w_acc      = (w_req0 & w_gnt0) | (w_req1 & w_gnt1);
  assign w_addr     = w_gnt1 ? m1_address : m0_address;
  assign w_wr       = w_gnt1 ? m1_write   : m0_write;
  assign w_in_range = ({1'b0, w_addr} < DEPTH_L);

  // A beat continues the current burst only if the owner itself was accepted.
  assign w_cont = ((r_state == ST_OWN0) & w_gnt0) | ((r_state == ST_OWN1) & w_gnt1);

  // Next ownership and burst count; a full burst yields to a waiting master.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_cnt_nxt   = '0;
    w_cnt_inc   = w_cont ? (r_cnt + CNT_W'(1)) : CNT_W'(1);
    if (w_acc) begin
      if (w_cnt_inc >= MAX_CNT) begin
        w_cnt_nxt = '0;
        if (w_gnt1) begin
          w_state_nxt = w_req0 ? ST_OWN0 : ST_OWN1;
        end else begin
          w_state_nxt = w_req1 ? ST_OWN1 : ST_OWN0;
        end
      end else begin
        w_cnt_nxt   = w_cnt_inc;
        w_state_nxt = w_gnt1 ? ST_OWN1 : ST_OWN0;
      end
    end else begin
      w_cnt_nxt   = '0;
      w_state_nxt = ST_IDLE;
    end
  end

  // State, history and read-return tracking registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_last    <= M1;
      r_rd_pend <= 1'b0;
      r_rd_id   <= M0;
      r_rd_oob  <= 1'b0;
      r_oob_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_last    <= w_acc ? (w_gnt1 ? M1 : M0) : r_last;
      r_rd_pend <= w_acc & ~w_wr;
      r_rd_id   <= w_gnt1 ? M1 : M0;
      r_rd_oob  <= ~w_in_range;
      r_oob_err <= w_acc & ~w_in_range;
    end
  end

  assign m0_waitrequest = w_req0 & ~w_gnt0;
  assign m1_waitrequest = w_req1 & ~w_gnt1;

  assign mem_address    = w_addr;
  assign mem_byteenable = w_gnt1 ? m1_byteenable : m0_byteenable;
  assign mem_writedata  = w_gnt1 ? m1_writedata  : m0_writedata;
  assign mem_chipselect = w_acc & w_in_range;
  assign mem_write      = mem_chipselect & w_wr;
  assign mem_clken      = ~reset;
  assign oob_err        = r_oob_err;

  // Out-of-range reads never touched the RAM, so return zero instead of stale data.
  assign w_rdata          = r_rd_oob ? '0 : mem_readdata;
  assign m0_readdata      = w_rdata;
  assign m1_readdata      = w_rdata;
  assign m0_readdatavalid = r_rd_pend & (r_rd_id == M0) & ~reset;
  assign m1_readdatavalid = r_rd_pend & (r_rd_id == M1) & ~reset;

endmodule

// File: tb/tb_audio_nios_onchip_mem_arbiter.sv
// Self-checking bench for the two-master on-chip memory arbiter.
module tb_audio_nios_onchip_mem_arbiter;

  localparam int ADDR_W    = 17;
  localparam int DATA_W    = 32;
  localparam int DEPTH     = 80000;
  localparam int MAX_BURST = 4;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          cyc;
  } rd_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [16:0] m0_address = '0, m1_address = '0;
  logic [3:0]  m0_byteenable = '0, m1_byteenable = '0;
  logic        m0_read = 1'b0, m1_read = 1'b0, m0_write = 1'b0, m1_write = 1'b0;
  logic [31:0] m0_writedata = '0, m1_writedata = '0;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_readdatavalid, m1_readdatavalid;
  logic [16:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken, oob_err;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = '0;

  logic [31:0] ram     [0:255] = '{default: 32'h0};
  logic [31:0] ref_mem [0:255] = '{default: 32'h0};
  rd_exp_t     sb_q[$];
  int          oob_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          v0_cnt = 0;
  int          v1_cnt = 0;
  bit          mon_en = 1'b0;

  always #5 clk = ~clk;

  audio_nios_onchip_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .mem_clken(mem_clken), .oob_err(oob_err)
  );

  function automatic logic [31:0] be_merge(input logic [31:0] old_w, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  // Behavioural single-port RAM: registered read data one cycle after the command.
  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) ram[mem_address[7:0]] <= be_merge(ram[mem_address[7:0]], mem_writedata, mem_byteenable);
      else           mem_readdata <= ram[mem_address[7:0]];
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: pop expected reads when valid shows, and track oob_err pulses.
  always @(negedge clk) begin
    if (mon_en) begin
      if (m0_readdatavalid || m1_readdatavalid) begin
        int          vid;
        logic [31:0] vd;
        rd_exp_t     e;
        vid = m1_readdatavalid ? 1 : 0;
        vd  = m1_readdatavalid ? m1_readdata : m0_readdata;
        if (m1_readdatavalid) v1_cnt++; else v0_cnt++;
        checks++;
        if (m0_readdatavalid && m1_readdatavalid) begin
          errors++;
          $display("FAIL both_valid: cycle %0d both readdatavalid high, required at most one", cyc);
        end else if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: m%0d valid data %h at cycle %0d, required none", vid, vd, cyc);
        end else begin
          e = sb_q.pop_front();
          if (e.id !== vid || e.cyc !== cyc || vd !== e.data) begin
            errors++;
            $display("FAIL read_return: got m%0d data %h cycle %0d, required m%0d data %h cycle %0d",
                     vid, vd, cyc, e.id, e.data, e.cyc);
          end
        end
      end else if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        rd_exp_t e;
        e = sb_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_valid: no valid at cycle %0d, required m%0d data %h", cyc, e.id, e.data);
      end
      begin
        bit exp_oob;
        while (oob_q.size() > 0 && oob_q[0] < cyc) void'(oob_q.pop_front());
        exp_oob = (oob_q.size() > 0 && oob_q[0] == cyc);
        if (exp_oob) void'(oob_q.pop_front());
        checks++;
        if (oob_err !== exp_oob) begin
          errors++;
          $display("FAIL oob_err: got %b at cycle %0d, required %b", oob_err, cyc, exp_oob);
        end
      end
    end
  end

  task automatic drive(input int id, input bit rd, input bit wr, input logic [16:0] addr,
                       input logic [3:0] be, input logic [31:0] wd);
    if (id == 0) begin
      m0_read = rd; m0_write = wr; m0_address = addr; m0_byteenable = be; m0_writedata = wd;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = addr; m1_byteenable = be; m1_writedata = wd;
    end
  endtask

  task automatic release_all();
    drive(0, 1'b0, 1'b0, 17'd0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 17'd0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // One beat from master id; called at posedge+1, returns at posedge+1 after acceptance.
  task automatic beat(input int id, input bit is_wr, input logic [16:0] addr, input logic [3:0] be,
                      input logic [31:0] wd, input bit expect_rd, output int waits);
    bit      oob;
    bit      accepted;
    rd_exp_t e;
    oob = (addr >= 17'(DEPTH));
    accepted = 1'b0;
    waits = 0;
    drive(id, !is_wr, is_wr, addr, be, wd);
    while (!accepted && waits < 50) begin
      @(negedge clk);
      if ((id == 0 ? m0_waitrequest : m1_waitrequest) === 1'b0) accepted = 1'b1;
      else begin
        waits++;
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!accepted) begin
      errors++;
      $display("FAIL beat_timeout: m%0d addr %0d not accepted, required acceptance", id, addr);
    end else begin
      checks++;
      if (mem_address !== addr || mem_chipselect !== !oob || mem_write !== (is_wr && !oob)) begin
        errors++;
        $display("FAIL mem_cmd: addr %0d cs %b we %b, required addr %0d cs %b we %b",
                 mem_address, mem_chipselect, mem_write, addr, !oob, is_wr && !oob);
      end
      if (is_wr && !oob) begin
        checks++;
        if (mem_writedata !== wd || mem_byteenable !== be) begin
          errors++;
          $display("FAIL mem_wdata: got %h/%h, required %h/%h", mem_writedata, mem_byteenable, wd, be);
        end
        ref_mem[addr[7:0]] = be_merge(ref_mem[addr[7:0]], wd, be);
      end
      if (!is_wr && expect_rd) begin
        e.id = id;
        e.data = oob ? 32'h0 : ref_mem[addr[7:0]];
        e.cyc = cyc + 1;
        sb_q.push_back(e);
      end
      if (oob) oob_q.push_back(cyc + 1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int w;
    reset = 1'b1;
    drive(0, 1'b1, 1'b0, 17'd1, 4'hF, 32'h0);
    drive(1, 1'b0, 1'b1, 17'd2, 4'hF, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL reset_wait: got %b%b, required 11", m0_waitrequest, m1_waitrequest);
    end
    checks++;
    if (mem_chipselect !== 1'b0 || mem_clken !== 1'b0 || m0_readdatavalid !== 1'b0 ||
        m1_readdatavalid !== 1'b0 || oob_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: cs %b clken %b v0 %b v1 %b oob %b, required all 0",
               mem_chipselect, mem_clken, m0_readdatavalid, m1_readdatavalid, oob_err);
    end
    @(posedge clk);
    #1;
    release_all();
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_clken !== 1'b1) begin
      errors++;
      $display("FAIL clken_run: got %b, required 1", mem_clken);
    end
    @(posedge clk);
    #1;
    w = 0;
  endtask

  task automatic test_write_read();
    int w1, w2;
    beat(0, 1'b1, 17'd5, 4'hF, 32'h12345678, 1'b1, w1);
    beat(0, 1'b0, 17'd5, 4'hF, 32'h0, 1'b1, w2);
    release_all();
    checks++;
    if (w1 !== 0 || w2 !== 0) begin
      errors++;
      $display("FAIL wr_rd_wait: waits %0d/%0d, required 0/0", w1, w2);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_round_robin();
    rd_exp_t e;
    int wtmp;
    beat(0, 1'b1, 17'd20, 4'hF, 32'hA0A0_0020, 1'b1, wtmp);
    beat(1, 1'b1, 17'd21, 4'hF, 32'hB1B1_0021, 1'b1, wtmp);
    release_all();
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    drive(0, 1'b1, 1'b0, 17'd20, 4'hF, 32'h0);
    drive(1, 1'b1, 1'b0, 17'd21, 4'hF, 32'h0);
    for (int k = 0; k < 12; k++) begin
      bit a0, a1, exp0;
      @(negedge clk);
      a0 = !m0_waitrequest;
      a1 = !m1_waitrequest;
      exp0 = (k < 4) || (k >= 8);
      checks++;
      if (a0 !== exp0 || a1 !== !exp0) begin
        errors++;
        $display("FAIL rr_grant: beat %0d accepted m0=%b m1=%b, required m0=%b m1=%b", k, a0, a1, exp0, !exp0);
      end
      e.id = exp0 ? 0 : 1;
      e.data = exp0 ? ref_mem[20] : ref_mem[21];
      e.cyc = cyc + 1;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
    end
    release_all();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_m1_burst();
    int w;
    int werr;
    int v0_start, v1_start;
    werr = 0;
    for (int i = 0; i < 6; i++) begin
      beat(1, 1'b1, 17'(30 + i), 4'hF, 32'hC000_0000 + 32'(i), 1'b1, w);
      if (w != 0) werr++;
    end
    v0_start = v0_cnt;
    v1_start = v1_cnt;
    for (int i = 0; i < 6; i++) begin
      beat(1, 1'b0, 17'(30 + i), 4'hF, 32'h0, 1'b1, w);
      if (w != 0) werr++;
    end
    release_all();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (werr !== 0) begin
      errors++;
      $display("FAIL m1_burst_wait: %0d beats stalled, required 0", werr);
    end
    checks++;
    if (v1_cnt - v1_start !== 6 || v0_cnt - v0_start !== 0) begin
      errors++;
      $display("FAIL m1_burst_valids: m1 %0d m0 %0d, required 6 and 0", v1_cnt - v1_start, v0_cnt - v0_start);
    end
  endtask

  task automatic test_oob();
    int w1, w2;
    beat(0, 1'b1, 17'd80000, 4'hF, 32'hDEAD_BEEF, 1'b1, w1);
    beat(0, 1'b0, 17'd80000, 4'hF, 32'h0, 1'b1, w2);
    release_all();
    checks++;
    if (w1 !== 0 || w2 !== 0) begin
      errors++;
      $display("FAIL oob_wait: waits %0d/%0d, required 0/0", w1, w2);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_byteenable();
    int w;
    beat(0, 1'b1, 17'd40, 4'hF, 32'hFFFF_FFFF, 1'b1, w);
    beat(0, 1'b1, 17'd40, 4'h3, 32'hAABB_CCDD, 1'b1, w);
    beat(0, 1'b0, 17'd40, 4'hF, 32'h0, 1'b1, w);
    release_all();
    checks++;
    if (ref_mem[40] !== 32'hFFFF_CCDD) begin
      errors++;
      $display("FAIL be_model: got %h, required ffffccdd", ref_mem[40]);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_read();
    int w;
    int v1_start;
    v1_start = v1_cnt;
    beat(1, 1'b0, 17'd30, 4'hF, 32'h0, 1'b0, w);
    reset = 1'b1;
    release_all();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (v1_cnt !== v1_start) begin
      errors++;
      $display("FAIL reset_drop_valid: %0d m1 valids, required 0", v1_cnt - v1_start);
    end
    drive(0, 1'b0, 1'b1, 17'd50, 4'hF, 32'h5050_5050);
    drive(1, 1'b0, 1'b1, 17'd51, 4'hF, 32'h5151_5151);
    @(negedge clk);
    checks++;
    if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_grant: wait m0 %b m1 %b, required 0 and 1", m0_waitrequest, m1_waitrequest);
    end
    ref_mem[50] = 32'h5050_5050;
    @(posedge clk);
    #1;
    drive(0, 1'b0, 1'b0, 17'd0, 4'h0, 32'h0);
    @(negedge clk);
    checks++;
    if (m1_waitrequest !== 1'b0) begin
      errors++;
      $display("FAIL handover: m1 wait %b, required 0", m1_waitrequest);
    end
    ref_mem[51] = 32'h5151_5151;
    @(posedge clk);
    #1;
    release_all();
    beat(0, 1'b0, 17'd51, 4'hF, 32'h0, 1'b1, w);
    release_all();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_round_robin();
    test_m1_burst();
    test_oob();
    test_byteenable();
    test_reset_mid_read();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (sb_q.size() !== 0 || oob_q.size() !== 0) begin
      errors++;
      $display("FAIL drain: %0d reads and %0d oob pulses outstanding, required 0", sb_q.size(), oob_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
